// File: rtl/game_pkg.sv
// Shared game-level definitions: FSM state encodings and screen/bird geometry
// used by the collision/score stage and the display logic.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    localparam int BIRD_X      = 200;
    localparam int BIRD_W      = 34;
    localparam int BIRD_H      = 24;
    localparam int SCREEN_H    = 480;
    localparam int SCREEN_WRAP = 849;

endpackage

// File: rtl/bcd3_counter.sv
// Three-digit BCD up-counter with synchronous clear; saturates at 999.
module bcd3_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] bcd
);

    logic [11:0] r_bcd;
    logic [11:0] w_bcd_inc;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_bcd_inc = r_bcd;
        if (r_bcd[3:0] != 4'd9) begin
            w_bcd_inc[3:0] = r_bcd[3:0] + 4'd1;
        end else if (r_bcd[7:4] != 4'd9) begin
            w_bcd_inc[3:0] = 4'd0;
            w_bcd_inc[7:4] = r_bcd[7:4] + 4'd1;
        end else if (r_bcd[11:8] != 4'd9) begin
            w_bcd_inc[7:0]  = 8'h00;
            w_bcd_inc[11:8] = r_bcd[11:8] + 4'd1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= 12'h000;
        end else if (clr) begin
            r_bcd <= 12'h000;
        end else if (inc) begin
            r_bcd <= w_bcd_inc;
        end
    end

    assign bcd = r_bcd;

endmodule

// File: rtl/tube_collide_score.sv
// Bird/tube and bird/ground collision detection, tube-pass scoring with a best
// score, and the IDLE/PLAY/HIT/OVER game FSM.
module tube_collide_score
    import game_pkg::*;
#(
    parameter int BIRD_X   = game_pkg::BIRD_X,
    parameter int BIRD_W   = game_pkg::BIRD_W,
    parameter int BIRD_H   = game_pkg::BIRD_H,
    parameter int SCREEN_H = game_pkg::SCREEN_H,
    parameter int HIT_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bird_v,
    input  logic [9:0]  lo_h,
    input  logic [9:0]  lo_v,
    input  logic [9:0]  lo_height,
    input  logic [9:0]  lo_width,
    input  logic [9:0]  up_h,
    input  logic [9:0]  up_v,
    input  logic [9:0]  up_height,
    input  logic [9:0]  up_width,
    output logic [1:0]  game_state,
    output logic        hit,
    output logic [11:0] score_bcd,
    output logic [11:0] best_bcd
);

    localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HIT_HOLD - 1);
    localparam logic [10:0] C_BX  = 11'(BIRD_X);
    localparam logic [10:0] C_BXR = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] C_BH  = 11'(BIRD_H);
    localparam logic [10:0] C_SH  = 11'(SCREEN_H);

    function automatic logic overlap(input logic [10:0] th, tv, tht, tw, by);
        return (th < C_BXR) && ((th + tw) > C_BX) &&
               (tv < (by + C_BH)) && ((tv + tht) > by);
    endfunction

    game_state_e   r_state, w_state_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic          r_hit, w_hit_next;
    logic [10:0]   r_prev_right;
    logic [11:0]   r_best;

    logic [10:0] w_bird_v, w_lo_right;
    logic        w_collide, w_pass, w_clr, w_inc, w_best_wr;

    assign w_bird_v   = {1'b0, bird_v};
    assign w_lo_right = {1'b0, lo_h} + {1'b0, lo_width};

    assign w_collide = overlap({1'b0, lo_h}, {1'b0, lo_v}, {1'b0, lo_height}, {1'b0, lo_width}, w_bird_v)
                     | overlap({1'b0, up_h}, {1'b0, up_v}, {1'b0, up_height}, {1'b0, up_width}, w_bird_v)
                     | ((w_bird_v + C_BH) >= C_SH);

    // The 0->849 wrap raises the right edge, so only a downward crossing of BIRD_X counts.
    assign w_pass = (r_prev_right >= C_BX) && (w_lo_right < C_BX);

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_hit_next   = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_best_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_PLAY;
                    w_clr        = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_collide) begin
                    w_state_next = ST_HIT;
                    w_hold_next  = HOLD_INIT;
                    w_hit_next   = 1'b1;
                    // Valid BCD orders the same as binary, hundreds digit most significant.
                    w_best_wr    = (score_bcd > r_best);
                end else begin
                    w_inc = w_pass;
                end
            end
            ST_HIT: begin
                if (r_hold == '0) begin
                    w_state_next = ST_OVER;
                end else begin
                    w_hold_next = r_hold - HW'(1);
                end
            end
            ST_OVER: begin
                if (start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_hit        <= 1'b0;
            r_prev_right <= '0;
            r_best       <= 12'h000;
        end else begin
            r_state      <= w_state_next;
            r_hold       <= w_hold_next;
            r_hit        <= w_hit_next;
            r_prev_right <= w_lo_right;
            if (w_best_wr) begin
                r_best <= score_bcd;
            end
        end
    end

    bcd3_counter u_score (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_inc),
        .bcd (score_bcd)
    );

    assign game_state = r_state;
    assign hit        = r_hit;
    assign best_bcd   = r_best;

endmodule

// File: tb/tb_tube_collide_score.sv
// Directed bench for tube_collide_score: an integer game model pushes expected
// outputs into a scoreboard each cycle; they are popped and checked after the edge.
module tb_tube_collide_score;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bird_v;
    logic [9:0]  lo_h, lo_v, lo_height, lo_width;
    logic [9:0]  up_h, up_v, up_height, up_width;
    logic [1:0]  game_state;
    logic        hit;
    logic [11:0] score_bcd, best_bcd;

    tube_collide_score dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bird_v     (bird_v),
        .lo_h       (lo_h),
        .lo_v       (lo_v),
        .lo_height  (lo_height),
        .lo_width   (lo_width),
        .up_h       (up_h),
        .up_v       (up_v),
        .up_height  (up_height),
        .up_width   (up_width),
        .game_state (game_state),
        .hit        (hit),
        .score_bcd  (score_bcd),
        .best_bcd   (best_bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        hit;
        logic [11:0] score;
        logic [11:0] best;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    int m_state, m_hold, m_score, m_best, m_prev;
    bit m_hit;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic bit ov(input int th, tv, tht, tw, bv);
        return (th < 234) && (th + tw > 200) && (tv < bv + 24) && (tv + tht > bv);
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_score = 0; m_best = 0; m_prev = 0; m_hit = 0;
    endtask

    task automatic set_tubes(input int h, input int bv);
        bird_v = 10'(bv);
        up_h = 10'(h); up_v = 10'd0;   up_height = 10'd240; up_width = 10'd60;
        lo_h = 10'(h); lo_v = 10'd360; lo_height = 10'd120; lo_width = 10'd60;
    endtask

    task automatic step(input bit st);
        int   lr;
        bit   col, pas, nh;
        exp_t e;
        start = st;
        lr  = int'(lo_h) + int'(lo_width);
        col = ov(lo_h, lo_v, lo_height, lo_width, bird_v) ||
              ov(up_h, up_v, up_height, up_width, bird_v) ||
              (int'(bird_v) + 24 >= 480);
        pas = (m_prev >= 200) && (lr < 200);
        nh  = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_score = 0; end
            1: begin
                if (col) begin
                    m_state = 2; m_hold = 3; nh = 1;
                    if (m_score > m_best) m_best = m_score;
                end else if (pas && m_score < 999) begin
                    m_score++;
                end
            end
            2: if (m_hold == 0) m_state = 3; else m_hold--;
            default: if (st) m_state = 0;
        endcase
        m_prev = lr;
        m_hit  = nh;
        sb.push_back('{st: 2'(m_state), hit: m_hit, score: to_bcd(m_score), best: to_bcd(m_best)});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("state", 12'(game_state), 12'(e.st));
            check("hit",   12'(hit),        12'(e.hit));
            check("score", score_bcd,       e.score);
            check("best",  best_bcd,        e.best);
        end
    endtask

    task automatic run_to_over();
        for (int i = 0; i < 4; i++) step(1'b0);
    endtask

    initial begin
        int passes;
        rst = 1'b1;
        start = 1'b0;
        set_tubes(600, 300);
        model_reset();
        #2;
        check("rst_state", 12'(game_state), 12'h000);
        check("rst_hit",   12'(hit),        12'h000);
        check("rst_score", score_bcd,       12'h000);
        check("rst_best",  best_bcd,        12'h000);
        #10;
        rst = 1'b0;

        // Single pass while sweeping the tube leftwards; start held late in PLAY.
        set_tubes(300, 300);
        step(1'b1);
        for (int h = 300; h >= 100; h--) begin
            set_tubes(h, 300);
            step(h < 120);
            if (h == 139) check("pass_score", score_bcd, 12'h001);
        end
        check("pass_no_hit", 12'(game_state), 12'h001);

        // Wrap 0 -> 849 must not score.
        set_tubes(0, 300);   step(1'b0);
        set_tubes(849, 300); step(1'b0);
        check("wrap_score", score_bcd, 12'h001);

        // Upper tube hit.
        set_tubes(180, 230);
        step(1'b0);
        check("tube_hit_state", 12'(game_state), 12'h002);
        check("tube_hit_pulse", 12'(hit),        12'h001);
        step(1'b0);
        check("tube_hit_pulse_end", 12'(hit), 12'h000);
        step(1'b0); step(1'b0); step(1'b0);
        check("tube_over", 12'(game_state), 12'h003);
        step(1'b1);
        check("over_idle_score_held", score_bcd, 12'h001);
        set_tubes(600, 300);
        step(1'b1);
        check("restart_score", score_bcd, 12'h000);

        // Three passes, then a ground hit records best = 003.
        for (int k = 0; k < 3; k++) begin
            set_tubes(140, 300); step(1'b0);
            set_tubes(139, 300); step(1'b0);
        end
        set_tubes(600, 460);
        step(1'b0);
        check("ground_hit_state", 12'(game_state), 12'h002);
        check("ground_best",      best_bcd,        12'h003);
        run_to_over();
        step(1'b1);
        step(1'b1);

        // Pass and collision in the same cycle: collision wins.
        set_tubes(140, 300); step(1'b0);
        set_tubes(139, 460); step(1'b0);
        check("pass_collide_state", 12'(game_state), 12'h002);
        check("pass_collide_score", score_bcd,       12'h000);
        run_to_over();
        step(1'b1);
        set_tubes(600, 300);
        step(1'b1);

        // Saturation and BCD carries.
        passes = 0;
        for (int k = 0; k < 1002; k++) begin
            set_tubes(140, 300); step(1'b0);
            set_tubes(139, 300); step(1'b0);
            passes++;
            if (passes == 10)   check("bcd_010", score_bcd, 12'h010);
            if (passes == 100)  check("bcd_100", score_bcd, 12'h100);
            if (passes == 1002) check("bcd_sat", score_bcd, 12'h999);
        end
        set_tubes(600, 460);
        step(1'b0);
        check("sat_best", best_bcd, 12'h999);

        // Asynchronous reset in the middle of HIT.
        step(1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sb.delete();
        check("mid_rst_state", 12'(game_state), 12'h000);
        check("mid_rst_hit",   12'(hit),        12'h000);
        check("mid_rst_score", score_bcd,       12'h000);
        check("mid_rst_best",  best_bcd,        12'h000);
        rst = 1'b0;
        set_tubes(600, 300);
        step(1'b0);
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
